// File: rtl/hilo_mult_unit_pkg.sv
// Shared opcode, state and width definitions for the HI/LO multiply issue/writeback unit.
package hilo_mult_unit_pkg;

  localparam int MUL_WIDTH = 32;
  localparam int MUL_OP_W  = 2;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_MTHI  = 2'd2,
    OP_MTLO  = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

endpackage

// File: rtl/hilo_unsigned_fix.sv
// Turns the core's signed product into an unsigned one for MULTU by adding back
// the operand that a set sign bit subtracted (mod 2^(2*WIDTH)).
module hilo_unsigned_fix #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] p,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_unsigned,
  output logic [2*WIDTH-1:0] p_fix
);

  logic [2*WIDTH-1:0] corr_a;
  logic [2*WIDTH-1:0] corr_b;

  always_comb begin
    corr_a = '0;
    corr_b = '0;
    if (is_unsigned && a[WIDTH-1]) corr_a = {b, {WIDTH{1'b0}}};
    if (is_unsigned && b[WIDTH-1]) corr_b = {a, {WIDTH{1'b0}}};
    p_fix = p + corr_a + corr_b;
  end

endmodule

// File: rtl/hilo_mult_unit.sv
// Issue/writeback stage around the sequential multiplier core; owns the HI/LO registers.
//   state    | meaning
//   IDLE     | ready for MULT/MULTU/MTHI/MTLO
//   START    | mul_start high for this one cycle
//   WAIT     | waiting for core finish (first cycle ignores finish)
//   WRITE    | commit corrected product to HI/LO
module hilo_mult_unit
  import hilo_mult_unit_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int OP_W  = MUL_OP_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [OP_W-1:0]    req_op,
  input  logic [WIDTH-1:0]   req_rs,
  input  logic [WIDTH-1:0]   req_rt,
  input  logic               abort,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic               busy,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  output logic               mul_start,
  input  logic               mul_finish,
  input  logic [2*WIDTH-1:0] mul_p
);

  state_t             state;
  logic               is_unsigned;
  logic               wait_first;
  logic [2*WIDTH-1:0] p_fix;

  hilo_unsigned_fix #(.WIDTH(WIDTH)) u_fix (
    .p           (mul_p),
    .a           (mul_a),
    .b           (mul_b),
    .is_unsigned (is_unsigned),
    .p_fix       (p_fix)
  );

  // Gated by rst_n so the pipeline sees no acceptance while reset is held.
  assign req_ready = rst_n && (state == ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      hi          <= '0;
      lo          <= '0;
      busy        <= 1'b0;
      mul_start   <= 1'b0;
      mul_a       <= '0;
      mul_b       <= '0;
      is_unsigned <= 1'b0;
      wait_first  <= 1'b0;
    end else begin
      mul_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid && !abort) begin
            case (op_t'(req_op))
              OP_MULT, OP_MULTU: begin
                mul_a       <= req_rs;
                mul_b       <= req_rt;
                is_unsigned <= (op_t'(req_op) == OP_MULTU);
                busy        <= 1'b1;
                mul_start   <= 1'b1;
                state       <= ST_START;
              end
              OP_MTHI: hi <= req_rs;
              OP_MTLO: lo <= req_rs;
              default: ;
            endcase
          end
        end
        ST_START: begin
          wait_first <= 1'b1;
          if (abort) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A finish left high by the previous operation is still visible here.
          wait_first <= 1'b0;
          if (abort) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (!wait_first && mul_finish) begin
            state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          hi    <= p_fix[2*WIDTH-1:WIDTH];
          lo    <= p_fix[WIDTH-1:0];
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_mult_unit.sv
// Scoreboard bench for hilo_mult_unit with a behavioural 33-cycle multiplier core.
module tb_hilo_mult_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [1:0]   req_op = 2'd0;
  logic [W-1:0] req_rs = '0;
  logic [W-1:0] req_rt = '0;
  logic         abort = 1'b0;
  logic [W-1:0] hi, lo, mul_a, mul_b;
  logic         busy, mul_start;
  logic         mul_finish = 1'b0;
  logic [2*W-1:0] mul_p = '0;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    string        name;
  } exp_t;
  exp_t sb[$];

  hilo_mult_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_rs     (req_rs),
    .req_rt     (req_rt),
    .abort      (abort),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_start  (mul_start),
    .mul_finish (mul_finish),
    .mul_p      (mul_p)
  );

  always #5 clk = ~clk;

  // Core model: finish stays high until one cycle after the next start is seen.
  int   core_cnt = 0;
  logic core_clr = 1'b0;
  always @(posedge clk) begin
    if (mul_start) begin
      core_cnt <= 33;
      core_clr <= 1'b1;
    end else begin
      if (core_clr) begin
        mul_finish <= 1'b0;
        core_clr   <= 1'b0;
      end
      if (core_cnt > 0) begin
        core_cnt <= core_cnt - 1;
        if (core_cnt == 1) begin
          mul_finish <= 1'b1;
          mul_p <= {{W{mul_a[W-1]}}, mul_a} * {{W{mul_b[W-1]}}, mul_b};
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every falling edge of busy must present the next expected HI/LO.
  initial begin
    logic bq;
    exp_t e;
    bq = 1'b0;
    forever begin
      @(negedge clk);
      if (bq && !busy) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: busy fell with no expected entry, hi=0x%0h lo=0x%0h", hi, lo);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_hi"}, hi, e.hi);
          chk({e.name, "_lo"}, lo, e.lo);
        end
      end
      bq = busy;
    end
  end

  task automatic issue_mul(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input string name, input logic [W-1:0] ehi, input logic [W-1:0] elo);
    exp_t e;
    e.hi = ehi; e.lo = elo; e.name = name;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_rs = a; req_rt = b;
    chk({name, "_ready"}, req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk({name, "_start"}, mul_start, 1);
    chk({name, "_mul_a"}, mul_a, a);
    chk({name, "_mul_b"}, mul_b, b);
    chk({name, "_busy"}, busy, 1);
    @(posedge clk); #1;
    chk({name, "_start_off"}, mul_start, 0);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done_in_budget"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    #2;
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_start", mul_start, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_mul_b", mul_b, 0);
    chk("rst_ready", req_ready, 0);
    #10 rst_n = 1'b1;
    #1 chk("ready_after_rst", req_ready, 1);

    // Back-to-back MTHI / MTLO
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd2; req_rs = 32'h12345678;
    chk("mthi_ready", req_ready, 1);
    @(posedge clk); #1;
    req_op = 2'd3; req_rs = 32'h9ABCDEF0;
    chk("mthi_hi", hi, 32'h12345678);
    chk("mthi_busy", busy, 0);
    chk("mtlo_ready", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("mtlo_lo", lo, 32'h9ABCDEF0);
    chk("mtlo_hi_kept", hi, 32'h12345678);
    chk("mtlo_busy", busy, 0);

    // MULTU 351*23, with an MTHI offered while busy
    issue_mul(2'd1, 32'd351, 32'd23, "multu_351x23", 32'h0, 32'h00001F89);
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd2; req_rs = 32'hDEADBEEF;
    chk("busy_ready_low", req_ready, 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("busy_hi_kept", hi, 32'h12345678);
    chk("busy_lo_kept", lo, 32'h9ABCDEF0);
    wait_idle("multu_351x23");

    issue_mul(2'd0, 32'hFFFFFFFE, 32'd3, "mult_m2x3", 32'hFFFFFFFF, 32'hFFFFFFFA);
    wait_idle("mult_m2x3");
    issue_mul(2'd1, 32'hFFFFFFFE, 32'd3, "multu_fex3", 32'h00000002, 32'hFFFFFFFA);
    wait_idle("multu_fex3");
    issue_mul(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max", 32'hFFFFFFFE, 32'h00000001);
    wait_idle("multu_max");

    // Abort in IDLE beats a simultaneous request
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd2; req_rs = 32'h00000055; abort = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; abort = 1'b0;
    chk("abort_idle_hi", hi, 32'hFFFFFFFE);
    chk("abort_idle_busy", busy, 0);

    // Abort mid-WAIT with the core still counting
    issue_mul(2'd0, 32'd7, 32'd9, "abort_wait", 32'hFFFFFFFE, 32'h00000001);
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_ready", req_ready, 1);
    chk("abort_hi", hi, 32'hFFFFFFFE);
    chk("abort_lo", lo, 32'h00000001);
    issue_mul(2'd0, 32'd2, 32'd3, "mult_2x3", 32'h0, 32'h6);
    wait_idle("mult_2x3");

    // Asynchronous reset pulse during WAIT
    issue_mul(2'd0, 32'd5, 32'd5, "rst_wait", 32'h0, 32'h0);
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_hi", hi, 0);
    chk("async_rst_lo", lo, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_ready", req_ready, 0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    issue_mul(2'd0, 32'hFFFFFFF9, 32'd6, "mult_m7x6", 32'hFFFFFFFF, 32'hFFFFFFD6);
    wait_idle("mult_m7x6");

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hilo_mult_unit.md
Name: hilo_mult_unit

Overview:
- Issue and writeback stage around the 32-bit sequential multiplier core.
- Accepts MULT, MULTU, MTHI and MTLO requests from the execute stage, and loads the multiplier operands.
- Pulses the multiplier's start, waits for its finish, then applies the unsigned correction for MULTU and writes the 64-bit product into the HI/LO architectural registers.
- Presents HI/LO and a busy flag that the pipeline uses to stall MFHI/MFLO.

Parameters:
- WIDTH, 32, operand width; the product is 2*WIDTH.
- OP_W, 2, width of the request opcode.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready at a rising edge.
- req_op  in  OP_W  opcode: 0=MULT (signed), 1=MULTU, 2=MTHI, 3=MTLO.
- req_rs  in  WIDTH  multiplicand, or the MTHI/MTLO data.
- req_rt  in  WIDTH  multiplier operand; ignored for MTHI/MTLO.
- abort  in  1  pipeline flush; discards an in-flight multiply.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- busy  out  1  multiply in flight; HI/LO are stale while high.
- mul_a  out  WIDTH  operand to the core, registered.
- mul_b  out  WIDTH  operand to the core, registered.
- mul_start  out  1  one-cycle start pulse to the core.
- mul_finish  in  1  core done level; stays high until the next start.
- mul_p  in  2*WIDTH  core product: signed two's-complement a*b.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; hi=0, lo=0, busy=0, mul_start=0, mul_a=0, mul_b=0. req_ready goes high once rst_n deasserts.
- States:
  - IDLE: req_ready=1. On an accepted MULT/MULTU: latch the operands into mul_a/mul_b, latch an is_unsigned flag, go to START.
  - START: mul_start=1 for exactly this cycle; go to WAIT.
  - WAIT: mul_finish is ignored in the first WAIT cycle, so a stale finish from the previous operation is not taken. From the second WAIT cycle on, mul_finish=1 causes a transition to WRITE.
  - WRITE: hi/lo <= corrected product; go to IDLE.
- Unsigned correction (MULTU, arithmetic mod 2^64):
  - p = mul_p + (mul_a[31] ? {mul_b,32'b0} : 0) + (mul_b[31] ? {mul_a,32'b0} : 0).
  - MULT uses mul_p unchanged.
- busy: high from the accepting edge through the WRITE edge. busy falls on the same edge that updates hi/lo.
- req_ready = (state==IDLE). No request of any kind is accepted while a multiply is in flight.
- MTHI/MTLO: accepted in IDLE only. hi (or lo) <= req_rs on the accepting edge. State stays IDLE, busy stays 0. Back-to-back MTHI/MTLO are allowed every cycle.
- Latency:
  - Accept at edge 0; mul_start high during cycle 1.
  - The core asserts finish after N cycles; HI/LO are written at the edge after finish is first sampled valid.
  - A new request can be accepted the cycle after WRITE.
- Abort:
  - In START/WAIT: go to IDLE next edge. hi/lo are unchanged and busy drops.
  - In WRITE: the write still completes, because it is architecturally committed.
  - In IDLE: no effect. An abort in the same cycle as req_valid takes precedence, and the request is not accepted.
  - The core is not reset by abort. Its later finish is ignored because the next operation's WAIT skips its first cycle and the core re-arms on the new start.
- Reset mid-operation: everything returns to reset values immediately and the product is lost.
- Illegal op values cannot occur with OP_W=2; all four codes are defined.

Decomposition:
- Shared package: opcode constants MULT/MULTU/MTHI/MTLO, state encodings, WIDTH.
- One sub-module, hilo_unsigned_fix: combinational 64-bit correction from (p, a, b, is_unsigned). It is natural to isolate it and unit-test it alone.
- The FSM, operand registers and HI/LO registers stay in the top.

Test Plan:
- MULTU 351*23 with a behavioural core model (finish after 33 cycles) -> mul_start is a single pulse the cycle after accept; hi=0x00000000, lo=0x00001F89; busy drops on the write edge.
- MULT 0xFFFFFFFE*3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 (exercises both correction terms).
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles -> both accepted, busy stays 0. A following MTHI offered while busy -> req_ready=0 and hi is unchanged until the multiply completes.
- Abort asserted mid-WAIT, with the core's finish still pending -> state goes to IDLE, hi/lo retain their prior values. A new MULT 2*3 then yields hi=0, lo=6, and the stale finish is not taken.
- rst_n pulsed low for 3 ns during WAIT -> hi=lo=0, busy=0 immediately (asynchronous). After release, the next MULT completes normally.
